// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259 acknowledge/EOI sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PENDING,
    ACK1,
    WAIT2,
    ACK2
  } pic_state_t;

  // OCW2 {R, SL, EOI} command codes
  localparam logic [2:0] NS_EOI       = 3'b001;
  localparam logic [2:0] S_EOI        = 3'b011;
  localparam logic [2:0] ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] ROT_S_EOI    = 3'b111;
  localparam logic [2:0] SET_PRI      = 3'b110;
  localparam logic [2:0] SET_ROT_AEOI = 3'b100;
  localparam logic [2:0] CLR_ROT_AEOI = 3'b000;

  function automatic logic [2:0] onehot_to_index(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/pic_ocw2_decoder.sv
// Combinational OCW2 decode into EOI mask, rotation and rotate-on-AEOI controls.
module pic_ocw2_decoder
  import pic_pkg::*;
(
  input  logic [7:0] ocw2_data,
  input  logic [7:0] highest_level_in_service,
  output logic [7:0] eoi_mask,
  output logic       rot_en,
  output logic [2:0] rot_level,
  output logic       set_rot_aeoi,
  output logic       clr_rot_aeoi
);

  logic [2:0] cmd;
  logic [2:0] lvl;
  logic       unused_bits;

  assign cmd         = ocw2_data[7:5];
  assign lvl         = ocw2_data[2:0];
  assign unused_bits = ^ocw2_data[4:3];

  always_comb begin
    eoi_mask     = '0;
    rot_en       = 1'b0;
    rot_level    = lvl;
    set_rot_aeoi = 1'b0;
    clr_rot_aeoi = 1'b0;
    case (cmd)
      NS_EOI: eoi_mask = highest_level_in_service;
      S_EOI:  eoi_mask = 8'b1 << lvl;
      ROT_NS_EOI: begin
        eoi_mask  = highest_level_in_service;
        // an empty ISR leaves the rotation untouched
        rot_en    = |highest_level_in_service;
        rot_level = onehot_to_index(highest_level_in_service);
      end
      ROT_S_EOI: begin
        eoi_mask = 8'b1 << lvl;
        rot_en   = 1'b1;
      end
      SET_PRI:      rot_en       = 1'b1;
      SET_ROT_AEOI: set_rot_aeoi = 1'b1;
      CLR_ROT_AEOI: clr_rot_aeoi = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pic_ack_sequencer.sv
// 8259 INT/INTA handshake, vector drive, OCW2 EOI/rotation and automatic EOI.
module pic_ack_sequencer
  import pic_pkg::*;
#(
  parameter int VEC_LSB_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] highest_request,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  input  logic [7:0] highest_level_in_service,
  output logic       int_out,
  output logic [7:0] interrupt,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  pic_state_t state, state_nx;
  logic       inta_n_d;
  logic       rotate_aeoi, rotate_aeoi_nx;
  logic [7:0] captured, captured_nx;
  logic       spurious, spurious_nx;
  logic       int_nx, data_out_en_nx;
  logic [7:0] interrupt_nx, eoi_nx, data_out_nx;
  logic [2:0] rotate_nx;
  logic       fall, rise;

  logic [7:0] dec_eoi;
  logic       dec_rot_en, dec_set_rae, dec_clr_rae;
  logic [2:0] dec_rot_level;

  logic [7:0] aeoi_mask;
  logic       aeoi_rot_en;

  assign fall = inta_n_d & ~inta_n;
  assign rise = ~inta_n_d & inta_n;

  pic_ocw2_decoder u_ocw2 (
    .ocw2_data                (ocw2_data),
    .highest_level_in_service (highest_level_in_service),
    .eoi_mask                 (dec_eoi),
    .rot_en                   (dec_rot_en),
    .rot_level                (dec_rot_level),
    .set_rot_aeoi             (dec_set_rae),
    .clr_rot_aeoi             (dec_clr_rae)
  );

  always_comb begin
    state_nx       = state;
    int_nx         = int_out;
    interrupt_nx   = '0;
    data_out_nx    = data_out;
    data_out_en_nx = data_out_en;
    captured_nx    = captured;
    spurious_nx    = spurious;
    aeoi_mask      = '0;
    aeoi_rot_en    = 1'b0;
    case (state)
      IDLE: begin
        if (|highest_request) begin
          state_nx = PENDING;
          int_nx   = 1'b1;
        end
      end
      PENDING: begin
        if (fall) begin
          state_nx = ACK1;
          int_nx   = 1'b0;
          if (|highest_request) begin
            captured_nx  = highest_request;
            spurious_nx  = 1'b0;
            interrupt_nx = highest_request;
          end else begin
            captured_nx = 8'b1000_0000;
            spurious_nx = 1'b1;
          end
        end
      end
      ACK1: begin
        if (rise) state_nx = WAIT2;
      end
      WAIT2: begin
        if (fall) begin
          state_nx       = ACK2;
          data_out_nx    = {vector_base, VEC_LSB_W'(onehot_to_index(captured))};
          data_out_en_nx = 1'b1;
        end
      end
      ACK2: begin
        if (rise) begin
          state_nx       = IDLE;
          data_out_en_nx = 1'b0;
          if (aeoi && !spurious) begin
            aeoi_mask   = captured;
            aeoi_rot_en = rotate_aeoi;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // OCW2 and AEOI can land together: EOI masks merge, OCW2 rotation takes precedence
  always_comb begin
    eoi_nx         = aeoi_mask;
    rotate_nx      = priority_rotate;
    rotate_aeoi_nx = rotate_aeoi;
    if (aeoi_rot_en) rotate_nx = onehot_to_index(captured);
    if (ocw2_write) begin
      eoi_nx = eoi_nx | dec_eoi;
      if (dec_rot_en)  rotate_nx      = dec_rot_level;
      if (dec_set_rae) rotate_aeoi_nx = 1'b1;
      if (dec_clr_rae) rotate_aeoi_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      inta_n_d         <= 1'b1;
      int_out          <= 1'b0;
      interrupt        <= '0;
      end_of_interrupt <= '0;
      priority_rotate  <= 3'b111;
      data_out         <= '0;
      data_out_en      <= 1'b0;
      rotate_aeoi      <= 1'b0;
      captured         <= '0;
      spurious         <= 1'b0;
    end else begin
      state            <= state_nx;
      inta_n_d         <= inta_n;
      int_out          <= int_nx;
      interrupt        <= interrupt_nx;
      end_of_interrupt <= eoi_nx;
      priority_rotate  <= rotate_nx;
      data_out         <= data_out_nx;
      data_out_en      <= data_out_en_nx;
      rotate_aeoi      <= rotate_aeoi_nx;
      captured         <= captured_nx;
      spurious         <= spurious_nx;
    end
  end

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Self-checking bench: OCW2 vector table, directed handshakes, randomized mix vs. a transaction model.
module tb_pic_ack_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] highest_request;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       ocw2_write;
  logic [7:0] ocw2_data;
  logic [7:0] highest_level_in_service;
  logic       int_out;
  logic [7:0] interrupt;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [7:0] data_out;
  logic       data_out_en;

  always #5 clk = ~clk;

  pic_ack_sequencer #(.VEC_LSB_W(3)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .highest_request          (highest_request),
    .inta_n                   (inta_n),
    .vector_base              (vector_base),
    .aeoi                     (aeoi),
    .ocw2_write               (ocw2_write),
    .ocw2_data                (ocw2_data),
    .highest_level_in_service (highest_level_in_service),
    .int_out                  (int_out),
    .interrupt                (interrupt),
    .end_of_interrupt         (end_of_interrupt),
    .priority_rotate          (priority_rotate),
    .data_out                 (data_out),
    .data_out_en              (data_out_en)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state: current lowest-priority level and rotate-on-AEOI flag
  logic [2:0] m_rot;
  logic       m_rae;

  typedef struct {
    logic [7:0] data;
    logic [7:0] isr;
    logic [7:0] exp_eoi;
    logic [2:0] exp_rot;
  } ocw_vec_t;

  ocw_vec_t tbl[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] level_of(input logic [7:0] oh);
    return 3'($clog2(oh));
  endfunction

  task automatic ocw2_apply(input logic [7:0] d, input logic [7:0] isr,
                            input logic [7:0] exp_eoi, input logic [2:0] exp_rot);
    ocw2_data                = d;
    highest_level_in_service = isr;
    ocw2_write               = 1'b1;
    tick();
    ocw2_write = 1'b0;
    chk("ocw2_eoi", end_of_interrupt, exp_eoi);
    chk("ocw2_rot", {5'b0, priority_rotate}, {5'b0, exp_rot});
    tick();
    chk("ocw2_eoi_gone", end_of_interrupt, 8'h00);
  endtask

  // model of one OCW2 write from the R/SL/EOI bit meanings
  task automatic ocw2_model(input logic [7:0] d, input logic [7:0] isr);
    logic [7:0] e;
    logic       r, sl, ei;
    logic [2:0] l;
    r = d[7]; sl = d[6]; ei = d[5]; l = d[2:0];
    e = 8'h00;
    if (ei) begin
      e = sl ? (8'h01 << l) : isr;
      if (r) begin
        if (sl) m_rot = l;
        else if (isr != 8'h00) m_rot = level_of(isr);
      end
    end else if (r && sl) m_rot = l;
    else if (r) m_rae = 1'b1;
    else if (!sl) m_rae = 1'b0;
    ocw2_apply(d, isr, e, m_rot);
  endtask

  task automatic handshake(input logic [7:0] req, input logic drop,
                           input logic [4:0] base, input logic ae);
    logic [2:0] idx;
    logic [7:0] exp_eoi;
    int         waited;
    idx     = drop ? 3'd7 : level_of(req);
    exp_eoi = (ae && !drop) ? req : 8'h00;
    vector_base     = base;
    aeoi            = ae;
    highest_request = req;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!int_out && waited < 8);
    chk("int_out_rise", {7'b0, int_out}, 8'h01);
    if (drop) begin
      highest_request = 8'h00;
      tick();
      chk("int_out_held", {7'b0, int_out}, 8'h01);
    end
    inta_n = 1'b0;
    tick();
    chk("irq_pulse", interrupt, drop ? 8'h00 : req);
    chk("int_out_drop", {7'b0, int_out}, 8'h00);
    highest_request = 8'h00;
    tick();
    chk("irq_single", interrupt, 8'h00);
    inta_n = 1'b1;
    tick();
    tick();
    inta_n = 1'b0;
    tick();
    chk("vec_en", {7'b0, data_out_en}, 8'h01);
    chk("vector", data_out, {base, idx});
    tick();
    chk("vec_en_hold", {7'b0, data_out_en}, 8'h01);
    inta_n = 1'b1;
    tick();
    if (ae && !drop && m_rae) m_rot = idx;
    chk("vec_release", {7'b0, data_out_en}, 8'h00);
    chk("aeoi_eoi", end_of_interrupt, exp_eoi);
    chk("aeoi_rot", {5'b0, priority_rotate}, {5'b0, m_rot});
    tick();
    chk("aeoi_single", end_of_interrupt, 8'h00);
    chk("idle_int", {7'b0, int_out}, 8'h00);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_rot = 3'b111;
    m_rae = 1'b0;
  endtask

  initial begin
    rst = 1'b1; highest_request = '0; inta_n = 1'b1; vector_base = '0; aeoi = 1'b0;
    ocw2_write = 1'b0; ocw2_data = '0; highest_level_in_service = '0;
    m_rot = 3'b111; m_rae = 1'b0;
    #1;
    chk("rst_int", {7'b0, int_out}, 8'h00);
    chk("rst_irq", interrupt, 8'h00);
    chk("rst_eoi", end_of_interrupt, 8'h00);
    chk("rst_rot", {5'b0, priority_rotate}, 8'h07);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_en", {7'b0, data_out_en}, 8'h00);
    do_reset();

    tbl[0] = '{8'hA0, 8'h10, 8'h10, 3'd4};
    tbl[1] = '{8'hC2, 8'h10, 8'h00, 3'd2};
    tbl[2] = '{8'h20, 8'h04, 8'h04, 3'd2};
    tbl[3] = '{8'h63, 8'h00, 8'h08, 3'd2};
    tbl[4] = '{8'hE5, 8'h01, 8'h20, 3'd5};
    tbl[5] = '{8'h40, 8'hFF, 8'h00, 3'd5};
    tbl[6] = '{8'hA0, 8'h00, 8'h00, 3'd5};
    tbl[7] = '{8'h20, 8'h00, 8'h00, 3'd5};
    for (int i = 0; i < 8; i++) ocw2_apply(tbl[i].data, tbl[i].isr, tbl[i].exp_eoi, tbl[i].exp_rot);

    do_reset();
    handshake(8'h08, 1'b0, 5'h10, 1'b0);
    chk("t1_vector_83", data_out, 8'h83);
    handshake(8'h20, 1'b0, 5'h10, 1'b1);
    handshake(8'h04, 1'b1, 5'h10, 1'b1);
    chk("t3_vector_87", data_out, 8'h87);
    ocw2_model(8'h80, 8'h00);
    handshake(8'h40, 1'b0, 5'h10, 1'b1);
    chk("t5_rot6", {5'b0, priority_rotate}, 8'h06);
    ocw2_model(8'h00, 8'h00);
    handshake(8'h02, 1'b0, 5'h10, 1'b1);
    chk("t5_rot_kept", {5'b0, priority_rotate}, 8'h06);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] oh;
      oh = 8'h01 << $urandom_range(7, 0);
      if ($urandom_range(1, 0) == 0) begin
        logic [7:0] d;
        logic [7:0] isr;
        d   = {3'($urandom_range(7, 0)), 2'b00, 3'($urandom_range(7, 0))};
        isr = ($urandom_range(3, 0) == 0) ? 8'h00 : oh;
        ocw2_model(d, isr);
      end else begin
        handshake(oh, $urandom_range(3, 0) == 0, 5'($urandom_range(31, 0)),
                  1'($urandom_range(1, 0)));
      end
    end

    // reset while the vector is on the bus
    ocw2_model(8'hC3, 8'h00);
    aeoi = 1'b1;
    highest_request = 8'h40;
    tick();
    tick();
    inta_n = 1'b0;
    tick();
    highest_request = 8'h00;
    tick();
    inta_n = 1'b1;
    tick();
    tick();
    inta_n = 1'b0;
    tick();
    chk("t6_en_before", {7'b0, data_out_en}, 8'h01);
    rst = 1'b1;
    #1;
    chk("t6_en_rst", {7'b0, data_out_en}, 8'h00);
    chk("t6_int_rst", {7'b0, int_out}, 8'h00);
    chk("t6_rot_rst", {5'b0, priority_rotate}, 8'h07);
    tick();
    inta_n = 1'b1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t6_no_irq", interrupt, 8'h00);
      chk("t6_no_eoi", end_of_interrupt, 8'h00);
      chk("t6_no_en", {7'b0, data_out_en}, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
